// File: rtl/uart_cmd_rx_if.sv
// rtl/uart_cmd_rx_if.sv - command receiver to latch/ALU/TX datapath bundle
// master: the receiver/decoder; slave: the downstream latch, ALU and TX stage.
interface uart_cmd_rx_if;
   logic [3:0] data_input;
   logic       save_a_n;
   logic       save_b_n;
   logic [3:0] ena;
   logic       uart_tx_en;
   logic       uartbusy;
   logic [7:0] rx_byte;
   logic       rx_valid;
   logic       frame_err;
   logic       cmd_err;

   modport master (
      output data_input, save_a_n, save_b_n, ena, uart_tx_en,
      output rx_byte, rx_valid, frame_err, cmd_err,
      input  uartbusy
   );

   modport slave (
      input  data_input, save_a_n, save_b_n, ena, uart_tx_en,
      input  rx_byte, rx_valid, frame_err, cmd_err,
      output uartbusy
   );
endinterface

// File: rtl/uart_cmd_rx.sv
// rtl/uart_cmd_rx.sv - UART 8N1 receiver with nibble command decoder
// Byte = {opcode, argument}; drives operand, latch strobes, ALU select and TX request.
module uart_cmd_rx #(
   parameter int CLK_FREQ  = 12_000_000,
   parameter int BAUD_RATE = 9600
) (
   input  logic          clk,
   input  logic          reset_n,
   input  logic          uart_rxd,
   uart_cmd_rx_if.master bus
);
   localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
   localparam int HALF_BIT     = CLKS_PER_BIT / 2;
   localparam int CNT_W        = $clog2(CLKS_PER_BIT) + 1;
   localparam logic [CNT_W-1:0] LAST_FULL = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [CNT_W-1:0] LAST_HALF = CNT_W'(HALF_BIT - 1);

   localparam logic [2:0] S_IDLE      = 3'd0;
   localparam logic [2:0] S_START     = 3'd1;
   localparam logic [2:0] S_DATA      = 3'd2;
   localparam logic [2:0] S_STOP      = 3'd3;
   localparam logic [2:0] S_EXEC      = 3'd4;
   localparam logic [2:0] S_PULSE     = 3'd5;
   localparam logic [2:0] S_WAIT_HIGH = 3'd6;

   localparam logic [3:0] OP_SAVE_A = 4'hA;
   localparam logic [3:0] OP_SAVE_B = 4'hB;
   localparam logic [3:0] OP_ENA    = 4'hE;
   localparam logic [3:0] OP_TX     = 4'h5;

   logic             r_rx_meta;
   logic             r_rxs;
   logic [2:0]       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [2:0]       r_bit_idx;
   logic [7:0]       r_shift;
   logic             r_busy;
   logic [3:0]       r_data_input;
   logic             r_save_a_n;
   logic             r_save_b_n;
   logic [3:0]       r_ena;
   logic             r_tx_en;
   logic [7:0]       r_rx_byte;
   logic             r_rx_valid;
   logic             r_frame_err;
   logic             r_cmd_err;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_rx_meta    <= 1'b1;
         r_rxs        <= 1'b1;
         r_state      <= S_IDLE;
         r_cnt        <= '0;
         r_bit_idx    <= '0;
         r_shift      <= '0;
         r_busy       <= 1'b0;
         r_data_input <= '0;
         r_save_a_n   <= 1'b1;
         r_save_b_n   <= 1'b1;
         r_ena        <= '0;
         r_tx_en      <= 1'b0;
         r_rx_byte    <= '0;
         r_rx_valid   <= 1'b0;
         r_frame_err  <= 1'b0;
         r_cmd_err    <= 1'b0;
      end else begin
         r_rx_meta   <= uart_rxd;
         r_rxs       <= r_rx_meta;
         // Every strobe and pulse defaults inactive, so none can outlast one cycle.
         r_save_a_n  <= 1'b1;
         r_save_b_n  <= 1'b1;
         r_tx_en     <= 1'b0;
         r_rx_valid  <= 1'b0;
         r_frame_err <= 1'b0;
         r_cmd_err   <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (!r_rxs) begin
                  r_state   <= S_START;
                  r_cnt     <= '0;
                  r_bit_idx <= '0;
               end
            end
            S_START: begin
               if (r_cnt == LAST_HALF) begin
                  r_cnt   <= '0;
                  r_state <= r_rxs ? S_IDLE : S_DATA;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DATA: begin
               if (r_cnt == LAST_FULL) begin
                  r_cnt     <= '0;
                  r_shift   <= {r_rxs, r_shift[7:1]};
                  r_bit_idx <= r_bit_idx + 1'b1;
                  if (r_bit_idx == 3'd7) begin
                     r_state <= S_STOP;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_STOP: begin
               if (r_cnt == LAST_FULL) begin
                  r_cnt <= '0;
                  if (r_rxs) begin
                     r_state <= S_EXEC;
                  end else begin
                     r_frame_err <= 1'b1;
                     r_state     <= S_WAIT_HIGH;
                  end
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_WAIT_HIGH: begin
               if (r_rxs) begin
                  r_state <= S_IDLE;
               end
            end
            S_EXEC: begin
               r_rx_byte  <= r_shift;
               r_rx_valid <= 1'b1;
               case (r_shift[7:4])
                  OP_SAVE_A, OP_SAVE_B: r_data_input <= r_shift[3:0];
                  OP_ENA:               r_ena        <= r_shift[3:0];
                  OP_TX:                r_busy       <= bus.uartbusy;
                  default:              r_cmd_err    <= 1'b1;
               endcase
               r_state <= S_PULSE;
            end
            S_PULSE: begin
               // r_rx_byte already holds the command decoded in EXEC.
               case (r_rx_byte[7:4])
                  OP_SAVE_A: r_save_a_n <= 1'b0;
                  OP_SAVE_B: r_save_b_n <= 1'b0;
                  OP_TX: begin
                     if (r_busy) begin
                        r_cmd_err <= 1'b1;
                     end else begin
                        r_tx_en <= 1'b1;
                     end
                  end
                  default: ;
               endcase
               r_state <= S_IDLE;
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.data_input = r_data_input;
   assign bus.save_a_n   = r_save_a_n;
   assign bus.save_b_n   = r_save_b_n;
   assign bus.ena        = r_ena;
   assign bus.uart_tx_en = r_tx_en;
   assign bus.rx_byte    = r_rx_byte;
   assign bus.rx_valid   = r_rx_valid;
   assign bus.frame_err  = r_frame_err;
   assign bus.cmd_err    = r_cmd_err;
endmodule

// File: tb/tb_uart_cmd_rx.sv
// tb/tb_uart_cmd_rx.sv - directed bench for uart_cmd_rx
// 16 clocks per bit; a negedge monitor counts pulses and records their cycle numbers.
module tb_uart_cmd_rx;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   logic uart_rxd = 1'b1;

   uart_cmd_rx_if bus ();

   uart_cmd_rx #(.CLK_FREQ(153_600), .BAUD_RATE(9600)) dut (
      .clk      (clk),
      .reset_n  (reset_n),
      .uart_rxd (uart_rxd),
      .bus      (bus)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_sa = 0, n_sb = 0, n_tx = 0, n_rv = 0, n_ce = 0, n_fe = 0, n_both = 0;
   int last_sa = 0, last_tx = 0, last_rv = 0, last_ce = 0;
   logic [3:0] di_at_rv = 4'h0, di_at_sb = 4'h0;

   always @(negedge clk) begin
      if (!bus.save_a_n) begin n_sa++; last_sa = cyc; end
      if (!bus.save_b_n) begin n_sb++; di_at_sb = bus.data_input; end
      if (!bus.save_a_n && !bus.save_b_n) n_both++;
      if (bus.uart_tx_en) begin n_tx++; last_tx = cyc; end
      if (bus.rx_valid) begin n_rv++; last_rv = cyc; di_at_rv = bus.data_input; end
      if (bus.cmd_err) begin n_ce++; last_ce = cyc; end
      if (bus.frame_err) n_fe++;
   end

   int total = 0;
   int bad = 0;
   int p_sa, p_sb, p_tx, p_rv, p_ce, p_fe;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic wait_clks(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic snap();
      p_sa = n_sa; p_sb = n_sb; p_tx = n_tx; p_rv = n_rv; p_ce = n_ce; p_fe = n_fe;
   endtask

   task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int stop_clks);
      uart_rxd = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 8; i++) begin
         uart_rxd = b[i];
         wait_clks(16);
      end
      uart_rxd = stop_bit;
      wait_clks(stop_clks);
      uart_rxd = 1'b1;
      wait_clks(24);
   endtask

   task automatic check_reset_values(input string pfx);
      check({pfx, "_data_input"}, 32'(bus.data_input), 32'h0);
      check({pfx, "_save_a_n"},   32'(bus.save_a_n),   32'h1);
      check({pfx, "_save_b_n"},   32'(bus.save_b_n),   32'h1);
      check({pfx, "_ena"},        32'(bus.ena),        32'h0);
      check({pfx, "_uart_tx_en"}, 32'(bus.uart_tx_en), 32'h0);
      check({pfx, "_rx_byte"},    32'(bus.rx_byte),    32'h0);
      check({pfx, "_rx_valid"},   32'(bus.rx_valid),   32'h0);
      check({pfx, "_frame_err"},  32'(bus.frame_err),  32'h0);
      check({pfx, "_cmd_err"},    32'(bus.cmd_err),    32'h0);
   endtask

   initial begin
      logic [7:0] partial;
      bus.uartbusy = 1'b0;
      wait_clks(3);
      check_reset_values("rst");
      reset_n = 1'b1;
      wait_clks(10);

      // 0xA5: operand A latch
      snap();
      send_frame(8'hA5, 1'b1, 16);
      check("a5_save_a_pulses", 32'(n_sa - p_sa), 32'd1);
      check("a5_rx_valid_pulses", 32'(n_rv - p_rv), 32'd1);
      check("a5_rx_byte", 32'(bus.rx_byte), 32'hA5);
      check("a5_data_input", 32'(bus.data_input), 32'h5);
      check("a5_data_at_rx_valid", 32'(di_at_rv), 32'h5);
      check("a5_strobe_after_valid", 32'(last_sa - last_rv), 32'd1);
      check("a5_no_cmd_err", 32'(n_ce - p_ce), 32'd0);
      check("a5_no_save_b", 32'(n_sb - p_sb), 32'd0);

      // 0xB3 then 0xE9
      snap();
      send_frame(8'hB3, 1'b1, 16);
      check("b3_save_b_pulses", 32'(n_sb - p_sb), 32'd1);
      check("b3_data_at_save_b", 32'(di_at_sb), 32'h3);
      check("b3_no_save_a", 32'(n_sa - p_sa), 32'd0);
      snap();
      send_frame(8'hE9, 1'b1, 16);
      check("e9_ena", 32'(bus.ena), 32'h9);
      check("e9_no_strobes", 32'((n_sa - p_sa) + (n_sb - p_sb)), 32'd0);
      check("e9_data_input_kept", 32'(bus.data_input), 32'h3);
      wait_clks(50);
      check("e9_ena_held", 32'(bus.ena), 32'h9);

      // 0x50: transmit request, idle then busy
      snap();
      send_frame(8'h50, 1'b1, 16);
      check("tx_idle_pulses", 32'(n_tx - p_tx), 32'd1);
      check("tx_idle_timing", 32'(last_tx - last_rv), 32'd1);
      check("tx_idle_no_cmd_err", 32'(n_ce - p_ce), 32'd0);
      snap();
      bus.uartbusy = 1'b1;
      send_frame(8'h50, 1'b1, 16);
      bus.uartbusy = 1'b0;
      check("tx_busy_no_request", 32'(n_tx - p_tx), 32'd0);
      check("tx_busy_cmd_err", 32'(n_ce - p_ce), 32'd1);
      check("tx_busy_cmd_err_timing", 32'(last_ce - last_rv), 32'd1);

      // 0x7F: unknown opcode
      snap();
      send_frame(8'h7F, 1'b1, 16);
      check("7f_cmd_err", 32'(n_ce - p_ce), 32'd1);
      check("7f_cmd_err_timing", 32'(last_ce - last_rv), 32'd0);
      check("7f_rx_byte", 32'(bus.rx_byte), 32'h7F);
      check("7f_data_input", 32'(bus.data_input), 32'h3);
      check("7f_ena", 32'(bus.ena), 32'h9);
      check("7f_no_strobes", 32'((n_sa - p_sa) + (n_sb - p_sb) + (n_tx - p_tx)), 32'd0);

      // 0xA1 with low stop bit, line held low, then good 0xA2
      snap();
      send_frame(8'hA1, 1'b0, 40);
      check("fe_frame_err", 32'(n_fe - p_fe), 32'd1);
      check("fe_no_rx_valid", 32'(n_rv - p_rv), 32'd0);
      check("fe_no_save_a", 32'(n_sa - p_sa), 32'd0);
      check("fe_rx_byte_kept", 32'(bus.rx_byte), 32'h7F);
      snap();
      send_frame(8'hA2, 1'b1, 16);
      check("a2_save_a_pulses", 32'(n_sa - p_sa), 32'd1);
      check("a2_data_input", 32'(bus.data_input), 32'h2);
      check("a2_rx_byte", 32'(bus.rx_byte), 32'hA2);

      // 4-clock glitch
      snap();
      uart_rxd = 1'b0;
      wait_clks(4);
      uart_rxd = 1'b1;
      wait_clks(200);
      check("glitch_no_rx_valid", 32'(n_rv - p_rv), 32'd0);
      check("glitch_no_frame_err", 32'(n_fe - p_fe), 32'd0);

      // reset during bit 4 of 0xA6
      snap();
      partial = 8'hA6;
      uart_rxd = 1'b0;
      wait_clks(16);
      for (int i = 0; i < 4; i++) begin
         uart_rxd = partial[i];
         wait_clks(16);
      end
      uart_rxd = partial[4];
      wait_clks(8);
      reset_n = 1'b0;
      #1;
      check_reset_values("midrst");
      uart_rxd = 1'b1;
      wait_clks(4);
      reset_n = 1'b1;
      wait_clks(200);
      check("midrst_no_strobes", 32'((n_sa - p_sa) + (n_sb - p_sb) + (n_tx - p_tx)), 32'd0);
      check("midrst_no_rx_valid", 32'(n_rv - p_rv), 32'd0);
      check("midrst_data_input", 32'(bus.data_input), 32'h0);
      check("never_both_strobes", 32'(n_both), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
